mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL provide parameter MULT_CYCLES, default 5, which sets the busy duration of mult/multu.
REQ-002 The block SHALL provide parameter DIV_CYCLES, default 10, which sets the busy duration of div/divu.
REQ-003 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL provide port start, input, 1 bit: command valid for the current cycle, driven by the EX stage.
REQ-006 The block SHALL provide port op, input, 3 bits: command select; 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0 and 7 are no-op.
REQ-007 The block SHALL provide port A, input, 32 bits: rs operand as forwarded from the register-file read path.
REQ-008 The block SHALL provide port B, input, 32 bits: rt operand as forwarded from the register-file read path.
REQ-009 The block SHALL provide port busy, output, 1 bit: registered; high while a mult/div is in flight.
REQ-010 The block SHALL provide port HI, output, 32 bits: registered HI register contents.
REQ-011 The block SHALL provide port LO, output, 32 bits: registered LO register contents.
REQ-012 The block SHALL provide port stall_req, output, 1 bit: combinational, equal to busy OR (start AND op in 1..4), for the hazard unit.

Function
REQ-013 The block SHALL have two states: IDLE (busy=0) and RUN (busy=1), with a down-counter cnt sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-014 The block SHALL accept a command only on a rising edge where start=1 and busy=0; start while busy=1 is ignored entirely, including mthi and mtlo.
REQ-015 On acceptance of mult or multu, the block SHALL compute the 64-bit product (signed or unsigned respectively) of A and B into internal pending registers, load cnt=MULT_CYCLES, and enter RUN.
REQ-016 On acceptance of div or divu, the block SHALL compute the quotient into pending-LO and the remainder into pending-HI, load cnt=DIV_CYCLES, and enter RUN.
REQ-017 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend A.
REQ-018 For signed division, 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-019 For division with B=0, the block SHALL still run DIV_CYCLES busy cycles, and HI/LO SHALL remain unchanged at completion.
REQ-020 In RUN, cnt SHALL decrement each cycle.
REQ-021 On the edge where cnt==1, the block SHALL load HI/LO from the pending registers, clear busy, and return to IDLE.
REQ-022 busy SHALL be high for exactly N cycles following the accepting edge, where N is MULT_CYCLES or DIV_CYCLES.
REQ-023 New HI/LO values SHALL be visible in the same cycle busy first reads 0.
REQ-024 HI and LO SHALL hold their previous values throughout RUN; operands A and B are sampled only at acceptance.
REQ-025 mthi SHALL set HI<=A on the accepting edge, with no busy cycles and LO unchanged.
REQ-026 mtlo SHALL set LO<=A on the accepting edge, with no busy cycles and HI unchanged.
REQ-027 A new command SHALL be acceptable on the edge in the cycle where busy first reads 0; a back-to-back issue SHALL be possible with zero idle cycles.
REQ-028 No-op values of op with start=1 SHALL change no state.

Reset
REQ-029 When reset=1 at a rising edge, the block SHALL set HI=0, LO=0, busy=0, cnt=0, and pending registers to 0, and enter IDLE.
REQ-030 Reset SHALL take priority over start and over an in-flight operation; a reset mid-RUN abandons the result, and HI/LO read 0 afterwards.
REQ-031 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 The bench SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-034 The bench SHALL cover: div with B=0 after mthi 0x1234 / mtlo 0x5678 -> 10 busy cycles, then HI=0x1234, LO=0x5678 unchanged.
REQ-035 The bench SHALL cover: mult in flight, then start with mtlo A=0xAAAA on busy cycle 2 -> ignored; LO equals the product at completion, and stall_req stays 1 throughout.
REQ-036 The bench SHALL cover: reset asserted on busy cycle 3 of a div -> next cycle busy=0, HI=0, LO=0, and no late update after 10 cycles.
REQ-037 The bench SHALL cover: mult issued on the first cycle busy reads 0 after a prior div -> accepted, with busy high 5 more cycles and no gap.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Purpose : groups the EX-stage command bus and the HI/LO result bus of the
//           multiply/divide unit into one bundle.
// Signals : start     - command valid for the current cycle
//           op        - command select (1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 0/7 no-op)
//           A, B      - rs / rt operands
//           busy      - registered, high while a mult/div is in flight
//           HI, LO    - registered HI/LO register contents
//           stall_req - combinational stall request for the hazard unit
// Modports: master (EX stage / testbench side), slave (the unit itself)
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stall_req;

  modport master (
    output start, op, A, B,
    input  busy, HI, LO, stall_req
  );

  modport slave (
    input  start, op, A, B,
    output busy, HI, LO, stall_req
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Purpose : MIPS-style HI/LO multiply/divide unit. The result is computed at
//           acceptance into pending registers and released to HI/LO after a
//           fixed number of busy cycles, so the pipeline sees a fixed latency.
// Ports   : clk   - single clock, rising edge
//           reset - synchronous, active-high
//           bus   - mult_div_unit_if.slave (start/op/A/B in,
//                   busy/HI/LO/stall_req out)
// Params  : MULT_CYCLES - busy duration of mult/multu
//           DIV_CYCLES  - busy duration of div/divu
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  mult_div_unit_if.slave    bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        is_muldiv;

  // Datapath. Signed division goes through magnitudes so that
  // 0x80000000 / -1 never hits a native signed overflow; its magnitude
  // quotient 0x80000000 is already the wrapped result. A zero divisor is
  // replaced by 1 only to keep the divider well defined; that result is
  // never committed.
  always_comb begin
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    div_b  = (bus.B == 32'd0) ? 32'd1 : bus.B;
    mag_a  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    mag_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
    mag_q  = mag_a / mag_b;
    mag_r  = mag_a % mag_b;
    quo_s  = (bus.A[31] ^ div_b[31]) ? (~mag_q + 32'd1) : mag_q;
    rem_s  = bus.A[31] ? (~mag_r + 32'd1) : mag_r;
    quo_u  = bus.A / div_b;
    rem_u  = bus.A % div_b;
  end

  assign is_muldiv = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

  // Control FSM. Commands are only looked at in IDLE, so anything issued
  // while busy (including mthi/mtlo) is dropped. For a divide by zero the
  // pending registers capture the current HI/LO, which cannot change during
  // RUN, so completion leaves HI/LO as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= (bus.op == OP_MULT) ? prod_s : prod_u;
                cnt    <= CNT_W'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.B == 32'd0) begin
                  pend_hi <= hi_q;
                  pend_lo <= lo_q;
                end else if (bus.op == OP_DIV) begin
                  pend_hi <= rem_s;
                  pend_lo <= quo_s;
                end else begin
                  pend_hi <= rem_u;
                  pend_lo <= quo_u;
                end
                cnt    <= CNT_W'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.stall_req = busy_q | is_muldiv;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Purpose : self-checking bench for mult_div_unit: a table of directed
//           vectors, hand-written multi-cycle sequences (ignored command
//           while busy, reset mid-divide, back-to-back issue) and random
//           commands checked against an arithmetic reference model.
// Ports   : none (top-level bench)
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mult_div_unit_if bus ();

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t table_v[12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd3: if (b != 0) begin
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) % longint'(sb);
        lo_m = q[31:0];
        hi_m = r[31:0];
      end
      3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int model_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Presents a command at the current time (expected away from posedge),
  // checks the stall request, and withdraws it just after the edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    #1;
    check("stall_req_at_issue", {31'd0, bus.stall_req}, {31'd0, (op >= 3'd1 && op <= 3'd4)});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts busy cycles at negedges; returns at the negedge where busy is 0.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
      cycles++;
    end
    miscompares++;
    vectors++;
    $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", cycles);
  endtask

  task automatic checkOutput(input string name, input int cycles, input int exp_cycles);
    check({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    check({name, "_HI"}, bus.HI, hi_m);
    check({name, "_LO"}, bus.LO, lo_m);
  endtask

  initial begin
    int cyc;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vectors     = 0;
    miscompares = 0;
    hi_m        = 32'd0;
    lo_m        = 32'd0;

    table_v[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    table_v[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, 5};
    table_v[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    table_v[3]  = '{3'd4, 32'd7,        32'd2,          32'd1,        32'd3,        10};
    table_v[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 10};
    table_v[5]  = '{3'd5, 32'h00001234, 32'd0,          32'h00001234, 32'h80000000, 0};
    table_v[6]  = '{3'd6, 32'h00005678, 32'd0,          32'h00001234, 32'h00005678, 0};
    table_v[7]  = '{3'd3, 32'd5,        32'd0,          32'h00001234, 32'h00005678, 10};
    table_v[8]  = '{3'd4, 32'd9,        32'd0,          32'h00001234, 32'h00005678, 10};
    table_v[9]  = '{3'd0, 32'hFFFF,     32'd3,          32'h00001234, 32'h00005678, 0};
    table_v[10] = '{3'd7, 32'hFFFF,     32'd3,          32'h00001234, 32'h00005678, 0};
    table_v[11] = '{3'd3, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, 10};

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_HI", bus.HI, 32'd0);
    check("reset_LO", bus.LO, 32'd0);
    check("reset_stall", {31'd0, bus.stall_req}, 32'd0);

    // Directed table, applied in sequence so state carries between rows.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(table_v[i].op, table_v[i].a, table_v[i].b);
      wait_done(cyc);
      hi_m = table_v[i].exp_hi;
      lo_m = table_v[i].exp_lo;
      checkOutput($sformatf("table%0d", i), cyc, table_v[i].exp_cycles);
    end

    // mtlo issued on busy cycle 2 of a mult is ignored.
    @(negedge clk);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'd2);
    model_apply(3'd1, 32'hFFFFFFFF, 32'd2);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) bus.start = 1'b0;
      #1;
      check($sformatf("ign_busy_c%0d", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("ign_stall_c%0d", i), {31'd0, bus.stall_req}, 32'd1);
      check($sformatf("ign_LO_hold_c%0d", i), bus.LO, 32'hFFFFFFFD);
      if (i == 2) begin
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.A     = 32'h0000AAAA;
      end
    end
    @(negedge clk);
    checkOutput("ignored_mtlo", 0, 0);
    check("ignored_mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // Reset on busy cycle 3 of a divide abandons it.
    applyStimulus(3'd5, 32'hDEAD0001, 32'd0);
    model_apply(3'd5, 32'hDEAD0001, 32'd0);
    @(negedge clk);
    applyStimulus(3'd3, 32'd100, 32'd7);
    for (int i = 1; i <= 3; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_HI", bus.HI, 32'd0);
    check("rst_mid_LO", bus.LO, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_no_late_HI", bus.HI, 32'd0);
      check("rst_no_late_LO", bus.LO, 32'd0);
      check("rst_no_late_busy", {31'd0, bus.busy}, 32'd0);
    end

    // Back-to-back: div, then mult issued in the first busy=0 cycle.
    applyStimulus(3'd4, 32'd100, 32'd7);
    model_apply(3'd4, 32'd100, 32'd7);
    wait_done(cyc);
    checkOutput("b2b_div", cyc, 10);
    applyStimulus(3'd2, 32'h00010000, 32'h00030000);
    model_apply(3'd2, 32'h00010000, 32'h00030000);
    wait_done(cyc);
    checkOutput("b2b_mult", cyc, 5);

    // Random commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      applyStimulus(rop, ra, rb);
      model_apply(rop, ra, rb);
      wait_done(cyc);
      checkOutput($sformatf("rand%0d_op%0d", i, rop), cyc, model_cycles(rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
